// File: rtl/disp_arbiter_if.sv
// Display-source bus between the requesters/alarm/floor logic and disp_arbiter.
// master drives the sources, slave is the arbiter that produces the display word.
interface disp_arbiter_if;
    logic [15:0] floor_data;
    logic [1:0]  msg_req;
    logic [15:0] msg_data0;
    logic [15:0] msg_data1;
    logic [1:0]  msg_ack;
    logic        alarm;
    logic [15:0] alarm_code;
    logic [15:0] dataBus;
    logic [1:0]  owner;

    modport master (
        output floor_data, msg_req, msg_data0, msg_data1, alarm, alarm_code,
        input  msg_ack, dataBus, owner
    );

    modport slave (
        input  floor_data, msg_req, msg_data0, msg_data1, alarm, alarm_code,
        output msg_ack, dataBus, owner
    );
endinterface

// File: rtl/disp_arbiter.sv
// Chooses the word shown on the 4-digit display: floor, two held messages (round-robin), blinking alarm.
// Optional macro ARB_PREEMPT_EN: the non-owning requester may cut a running message short.
module disp_arbiter #(
    parameter int unsigned HOLD_CYC  = 760,
    parameter int unsigned BLINK_CYC = 190
) (
    input  logic          clk380hz,
    input  logic          rst,
    disp_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MSG, ALARM} state_e;

    localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_CYC - 1);

    state_e      state_q;
    logic        rr_q;
    logic        gnt_q;
    logic [15:0] msg_q;
    logic [15:0] hold_q;
    logic [15:0] blink_q;
    logic        phase_q;
    logic [15:0] data_q;
    logic [1:0]  owner_q;
    logic [1:0]  ack_q;

    logic        any_req;
    logic        gsel_d;

    // With both requesting the rr pointer decides; otherwise the lone requester wins.
    always_comb begin
        any_req = |bus.msg_req;
        gsel_d  = (bus.msg_req == 2'b11) ? rr_q : bus.msg_req[1];
    end

    // Outputs are loaded from the current state, so they trail each decision by one cycle.
    always_ff @(posedge clk380hz) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            msg_q   <= '0;
            hold_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            data_q  <= '0;
            owner_q <= 2'd0;
            ack_q   <= 2'b00;
        end else begin
            ack_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    data_q  <= bus.floor_data;
                    owner_q <= 2'd0;
                    blink_q <= '0;
                    phase_q <= 1'b0;
                    if (bus.alarm) begin
                        state_q <= ALARM;
                    end else if (any_req) begin
                        ack_q   <= gsel_d ? 2'b10 : 2'b01;
                        msg_q   <= gsel_d ? bus.msg_data1 : bus.msg_data0;
                        gnt_q   <= gsel_d;
                        rr_q    <= ~gsel_d;
                        hold_q  <= HOLD_LOAD;
                        state_q <= MSG;
                    end
                end

                MSG: begin
                    data_q  <= msg_q;
                    owner_q <= {1'b0, gnt_q} + 2'd1;
                    if (bus.alarm) begin
                        state_q <= ALARM;
                        hold_q  <= '0;
                        blink_q <= '0;
                        phase_q <= 1'b0;
                    end
`ifdef ARB_PREEMPT_EN
                    else if (bus.msg_req[~gnt_q]) begin
                        ack_q  <= gnt_q ? 2'b01 : 2'b10;
                        msg_q  <= gnt_q ? bus.msg_data0 : bus.msg_data1;
                        gnt_q  <= ~gnt_q;
                        rr_q   <= gnt_q;
                        hold_q <= HOLD_LOAD;
                    end
`endif
                    else if (hold_q == 16'd0) begin
                        state_q <= IDLE;
                    end else begin
                        hold_q <= hold_q - 16'd1;
                    end
                end

                ALARM: begin
                    owner_q <= 2'd3;
                    data_q  <= phase_q ? 16'hFFFF : bus.alarm_code;
                    if (!bus.alarm) begin
                        state_q <= IDLE;
                        blink_q <= '0;
                        phase_q <= 1'b0;
                    end else if (blink_q >= BLINK_LAST) begin
                        blink_q <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        blink_q <= blink_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dataBus = data_q;
    assign bus.owner   = owner_q;
    assign bus.msg_ack = ack_q;
endmodule
